ps2_dev_tx: RTL and testbench

PS/2 device-side transmitter. It serialises scan-code bytes onto ps2_clk/ps2_data exactly as a keyboard does, so it is the other end of the calculator's PS/2 receiver. It is used as a synthesizable keyboard model in xtop benches and in loopback builds, where it replaces the free-running ps2_clk stimulus with real framed traffic. It generates the PS/2 clock itself and honours host inhibit (host holding clock low) by aborting and retransmitting.

---
 rtl/ps2_dev_tx.sv | 177 +++++++++++++++++
 tb/tb_ps2_dev_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx: PS/2 device-side (keyboard-style) byte transmitter.
//
// Serialises a byte as an 11-bit PS/2 frame (start 0, d0..d7, odd parity,
// stop 1), generating ps2_clk itself. If the host holds the clock low during
// a high phase, the frame is abandoned, the byte kept, and the whole frame is
// resent from its start bit once the host lets go and an idle gap has passed.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   tx_data     byte to send, captured on accept
//   tx_valid    byte available
//   tx_ready    can accept; transfer on tx_valid && tx_ready at a rising edge
//   ps2_clk_o   PS/2 clock level driven by the device (idle 1)
//   ps2_data_o  PS/2 data level driven by the device (idle 1)
//   ps2_clk_i   wired clock line as seen by the device, asynchronous
//   busy        frame, hold or gap in progress
//   tx_done     one-cycle pulse, frame completed
//   tx_abort    one-cycle pulse, frame abandoned because of host inhibit
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | lines high, tx_ready follows !inhibit
// S_HIGH | ps2_clk_o high for HALF_PERIOD cycles, current bit on data
// S_LOW  | ps2_clk_o low for HALF_PERIOD cycles, data held
// S_GAP  | lines high for GAP_CYCLES, then idle or retransmit
// S_HOLD | frame abandoned, waiting for host to release the clock
module ps2_dev_tx #(
  parameter int HALF_PERIOD = 3000,
  parameter int GAP_CYCLES  = 6000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  input  logic       ps2_clk_i,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam int TMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HP_LOAD  = TW'(HALF_PERIOD - 1);
  // Timer values below this mean at least two HIGH cycles have elapsed.
  localparam logic [TW-1:0] HP_GUARD = TW'(HALF_PERIOD - 2);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_GAP, S_HOLD} state_t;

  state_t        state;
  logic [10:0]   frame;
  logic [3:0]    bit_idx;
  logic [TW-1:0] timer;
  logic          retry;
  logic          sync_q1;
  logic          sync_q2;
  logic          inhibit;
  logic          accept;
  logic [3:0]    idx_nxt;

  assign inhibit = ~sync_q2;
  assign accept  = tx_valid & tx_ready;
  assign idx_nxt = bit_idx + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= ps2_clk_i;
      sync_q2 <= sync_q1;
    end
  end

  // tx_ready is loaded from sync_q1 so that, once registered, it equals
  // !inhibit in the same cycle rather than one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      frame      <= '0;
      bit_idx    <= '0;
      timer      <= '0;
      retry      <= 1'b0;
      ps2_clk_o  <= 1'b1;
      ps2_data_o <= 1'b1;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            frame      <= {1'b1, ~^tx_data, tx_data, 1'b0};
            bit_idx    <= '0;
            timer      <= HP_LOAD;
            ps2_clk_o  <= 1'b1;
            ps2_data_o <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= S_HIGH;
          end else begin
            tx_ready <= sync_q1;
          end
        end
        S_HIGH: begin
          // The first two HIGH cycles still see our own low phase through
          // the synchroniser, so inhibit is only trusted after them.
          if (inhibit && (timer < HP_GUARD)) begin
            ps2_clk_o  <= 1'b1;
            ps2_data_o <= 1'b1;
            tx_abort   <= 1'b1;
            retry      <= 1'b1;
            state      <= S_HOLD;
          end else if (timer == '0) begin
            ps2_clk_o <= 1'b0;
            timer     <= HP_LOAD;
            state     <= S_LOW;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_LOW: begin
          if (timer == '0) begin
            ps2_clk_o <= 1'b1;
            if (bit_idx == 4'd10) begin
              ps2_data_o <= 1'b1;
              tx_done    <= 1'b1;
              retry      <= 1'b0;
              timer      <= GAP_LOAD;
              state      <= S_GAP;
            end else begin
              bit_idx    <= idx_nxt;
              ps2_data_o <= frame[idx_nxt];
              timer      <= HP_LOAD;
              state      <= S_HIGH;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_GAP: begin
          if (timer == '0) begin
            if (retry) begin
              bit_idx    <= '0;
              ps2_data_o <= frame[0];
              timer      <= HP_LOAD;
              state      <= S_HIGH;
            end else begin
              busy     <= 1'b0;
              tx_ready <= sync_q1;
              state    <= S_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_HOLD: begin
          if (!inhibit) begin
            timer <= GAP_LOAD;
            state <= S_GAP;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb_ps2_dev_tx: bench for ps2_dev_tx with HALF_PERIOD=8, GAP_CYCLES=16.
// A timeline model (frame start cycle + arithmetic on the offset into the
// frame) predicts every output on every cycle; directed scenarios add literal
// expectations for frame contents and timing, then a randomized phase mixes
// bytes, valid gaps and host inhibit pulses.
module tb_ps2_dev_tx;
  localparam int HP  = 8;
  localparam int GAP = 16;
  localparam int FRAME_LEN = 22 * HP;

  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_GAP   = 2;
  localparam int M_HOLD  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_o;
  logic       ps2_data_o;
  logic       ps2_clk_i;
  logic       busy;
  logic       tx_done;
  logic       tx_abort;

  ps2_dev_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_data_o (ps2_data_o),
    .ps2_clk_i  (ps2_clk_i),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state
  int          m_mode;
  int          m_fs, m_gs, m_hs;
  bit          m_gap_done, m_retry, m_rst_out;
  bit          m_s1, m_s2;
  logic [10:0] m_frame;
  int          m_acc_cnt = 0;
  int          m_acc_cyc = 0;

  // observations of the DUT
  int d_done_cnt = 0, d_done_cyc = -1, d_abort_cnt = 0;
  int d_ready_rise_cyc = -1, d_ready_hi_cnt = 0;
  bit d_prev_clk = 1'b1, d_prev_ready = 1'b0;
  bit fall_bits [4096];
  int fall_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_s1      = 1'b1;
    m_s2      = 1'b1;
    m_retry   = 1'b0;
    m_rst_out = 1'b1;
  endtask

  task automatic eval_cycle();
    logic [5:0] exp_v, act_v;
    int k, ph;
    bit inh;
    act_v = {ps2_clk_o, ps2_data_o, tx_ready, busy, tx_done, tx_abort};
    if (tx_done) begin d_done_cnt++; d_done_cyc = cyc; end
    if (tx_abort) d_abort_cnt++;
    if (tx_ready) d_ready_hi_cnt++;
    if (tx_ready && !d_prev_ready) d_ready_rise_cyc = cyc;
    if (d_prev_clk && !ps2_clk_o) begin
      fall_bits[fall_cnt % 4096] = ps2_data_o;
      fall_cnt++;
    end
    d_prev_clk   = ps2_clk_o;
    d_prev_ready = tx_ready;

    exp_v = 6'b110000;
    if (!rst) model_reset();
    else if (!m_rst_out) begin
      case (m_mode)
        M_IDLE:  exp_v = {1'b1, 1'b1, m_s2, 3'b000};
        M_FRAME: begin
          k  = cyc - m_fs;
          ph = k % (2 * HP);
          exp_v = {(ph < HP), m_frame[k / (2 * HP)], 1'b0, 1'b1, 2'b00};
        end
        M_GAP:   exp_v = {4'b1101, (m_gap_done && cyc == m_gs), 1'b0};
        default: exp_v = {4'b1101, 1'b0, (cyc == m_hs)};
      endcase
    end
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs cycle %0d: got clk,data,ready,busy,done,abort=%b expected %b",
               cyc, act_v, exp_v);
    end

    if (rst) begin
      inh = !m_s2;
      if (m_rst_out) m_rst_out = 1'b0;
      else begin
        case (m_mode)
          M_IDLE: if (m_s2 && tx_valid) begin
            m_frame[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_frame[i+1] = tx_data[i];
            m_frame[9]  = ($countones(tx_data) % 2 == 0);
            m_frame[10] = 1'b1;
            m_acc_cnt++;
            m_acc_cyc = cyc;
            m_fs   = cyc + 1;
            m_mode = M_FRAME;
          end
          M_FRAME: begin
            k  = cyc - m_fs;
            ph = k % (2 * HP);
            if (ph >= 2 && ph < HP && inh) begin
              m_mode = M_HOLD; m_hs = cyc + 1; m_retry = 1'b1;
            end else if (k == FRAME_LEN - 1) begin
              m_mode = M_GAP; m_gs = cyc + 1; m_gap_done = 1'b1; m_retry = 1'b0;
            end
          end
          M_GAP: if (cyc == m_gs + GAP - 1) begin
            if (m_retry) begin m_mode = M_FRAME; m_fs = cyc + 1; end
            else m_mode = M_IDLE;
          end
          default: if (!inh) begin
            m_mode = M_GAP; m_gs = cyc + 1; m_gap_done = 1'b0;
          end
        endcase
      end
      m_s2 = m_s1;
      m_s1 = ps2_clk_i;
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int n0, input string name, output int acc);
    int n = 0;
    while (m_acc_cnt == n0 && n < 600) begin step(); n++; end
    check(name, (m_acc_cnt != n0), 1);
    acc = m_acc_cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input string name, output int acc);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_accept(m_acc_cnt, name, acc);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (d_done_cnt < target && n < 600) begin step(); n++; end
    check(name, (d_done_cnt >= target), 1);
  endtask

  function automatic logic [10:0] get_word(input int base);
    logic [10:0] w;
    for (int i = 0; i < 11; i++) w[i] = fall_bits[(base + i) % 4096];
    return w;
  endfunction

  initial begin
    int acc, acc2, base, d0, a0, r0, rel, d1, n, inh_left;
    rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; ps2_clk_i = 1'b1;
    model_reset();
    @(posedge clk); #1;
    repeat (3) step();
    check("reset_clk",   ps2_clk_o,  1);
    check("reset_data",  ps2_data_o, 1);
    check("reset_ready", tx_ready,   0);
    check("reset_busy",  busy,       0);
    rst = 1'b1;
    repeat (3) step();

    // 1: 0x1C framing and timing
    base = fall_cnt; d0 = d_done_cnt;
    send_byte(8'h1C, "t1_accept", acc);
    wait_done(d0 + 1, "t1_done_seen");
    check("t1_done_time", d_done_cyc, acc + 1 + 176);
    check("t1_word_1C", get_word(base), 11'h438);
    n = 0;
    while (d_ready_rise_cyc <= d_done_cyc && n < 100) begin step(); n++; end
    check("t1_ready_time", d_ready_rise_cyc, acc + 1 + 176 + 16);

    // 2: 0x00, parity 1
    base = fall_cnt; d0 = d_done_cnt;
    send_byte(8'h00, "t2_accept", acc);
    wait_done(d0 + 1, "t2_done_seen");
    check("t2_word_00", get_word(base), 11'h600);

    // 3: back-to-back 0xF0 then 0x1C with tx_valid held
    base = fall_cnt; d0 = d_done_cnt;
    tx_data = 8'hF0; tx_valid = 1'b1;
    wait_accept(m_acc_cnt, "t3_accept1", acc);
    tx_data = 8'h1C;
    wait_done(d0 + 1, "t3_done1_seen");
    d1 = d_done_cyc;
    wait_accept(m_acc_cnt, "t3_accept2", acc2);
    tx_valid = 1'b0;
    wait_done(d0 + 2, "t3_done2_seen");
    check("t3_done1_time", d1, acc + 1 + 176);
    check("t3_gap_to_accept2", acc2 - d1, GAP);
    check("t3_word_F0", get_word(base), 11'h7E0);
    check("t3_word_1C", get_word(base + 11), 11'h438);

    // 4: host inhibit from idle blocks the accept
    ps2_clk_i = 1'b0;
    repeat (4) step();
    r0 = d_ready_hi_cnt; a0 = m_acc_cnt;
    tx_data = 8'h3A; tx_valid = 1'b1;
    repeat (20) step();
    check("t4_ready_blocked", d_ready_hi_cnt - r0, 0);
    check("t4_no_accept", m_acc_cnt - a0, 0);
    base = fall_cnt; d0 = d_done_cnt;
    ps2_clk_i = 1'b1;
    rel = cyc;
    wait_accept(a0, "t4_accept", acc);
    tx_valid = 1'b0;
    check("t4_accept_within_3", (acc - rel <= 3), 1);
    wait_done(d0 + 1, "t4_done_seen");
    check("t4_word_3A", get_word(base), 11'h674);

    // 5: inhibit during bit 5 high phase, retransmission
    d0 = d_done_cnt; a0 = d_abort_cnt;
    send_byte(8'h5A, "t5_accept", acc);
    while (cyc < acc + 1 + 82) step();
    ps2_clk_i = 1'b0;
    repeat (40) step();
    ps2_clk_i = 1'b1;
    check("t5_abort_once", d_abort_cnt - a0, 1);
    check("t5_no_done_before_retry", d_done_cnt - d0, 0);
    base = fall_cnt;
    wait_done(d0 + 1, "t5_done_seen");
    check("t5_word_5A", get_word(base), 11'h6B4);
    repeat (30) step();
    check("t5_done_once", d_done_cnt - d0, 1);
    check("t5_abort_still_once", d_abort_cnt - a0, 1);

    // 6: reset during bit 3
    send_byte(8'h96, "t6_accept", acc);
    while (cyc < acc + 1 + 3 * 2 * HP + 10) step();
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_clk",   ps2_clk_o,  1);
    check("t6_rst_data",  ps2_data_o, 1);
    check("t6_rst_ready", tx_ready,   0);
    check("t6_rst_busy",  busy,       0);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    base = fall_cnt; d0 = d_done_cnt;
    send_byte(8'h1C, "t6_accept2", acc);
    wait_done(d0 + 1, "t6_done_seen");
    check("t6_word_1C", get_word(base), 11'h438);

    // randomized traffic with host inhibit pulses
    inh_left = 0;
    repeat (4000) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      if (inh_left > 0) inh_left--;
      else if ($urandom_range(0, 149) == 0) inh_left = $urandom_range(1, 40);
      ps2_clk_i = (inh_left == 0);
      step();
    end
    tx_valid  = 1'b0;
    ps2_clk_i = 1'b1;
    repeat (300) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
